// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - two-button press/release/long/repeat event generator with event FIFO; optional macro BTN_REPEAT_EN
module btn_event_ctrl #(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [1:0]                    btn_in,
  output logic                          evt_valid,
  output logic [2:0]                    evt_code,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(LONG_TICKS + 1);
`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
`endif

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;
`ifdef BTN_REPEAT_EN
  localparam logic [1:0] T_REPEAT  = 2'b11;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DOWN = 2'b01,
    S_LONG = 2'b10
  } state_t;

  state_t          state_q [2];
  state_t          state_d [2];
  logic [HW-1:0]   hold_q  [2];
  logic [HW-1:0]   hold_d  [2];
`ifdef BTN_REPEAT_EN
  logic [RW-1:0]   rep_q   [2];
  logic [RW-1:0]   rep_d   [2];
`endif
  logic [1:0]      prev_smp;
  logic [1:0]      emit;
  logic [1:0]      etype   [2];

  // event staging: slot a is offered to the FIFO this cycle, slot b holds btn_c behind btn_r
  logic            ev_a_v;
  logic [2:0]      ev_a_code;
  logic            ev_b_v;
  logic [2:0]      ev_b_code;

  logic [2:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            push_ok;

  // button FSM state, hold/repeat counters and previous sample advance only on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_smp <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= S_IDLE;
        hold_q[b]  <= '0;
`ifdef BTN_REPEAT_EN
        rep_q[b]   <= '0;
`endif
      end
    end else if (tick) begin
      prev_smp <= btn_in;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        hold_q[b]  <= hold_d[b];
`ifdef BTN_REPEAT_EN
        rep_q[b]   <= rep_d[b];
`endif
      end
    end
  end

  // next-state and event decode; a level is stable when this and the previous tick sample agree
  always_comb begin
    emit = 2'b00;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      hold_d[b]  = hold_q[b];
`ifdef BTN_REPEAT_EN
      rep_d[b]   = rep_q[b];
`endif
      etype[b]   = T_PRESS;
      case (state_q[b])
        S_IDLE: begin
          if (btn_in[b] && prev_smp[b]) begin
            state_d[b] = S_DOWN;
            hold_d[b]  = '0;
            emit[b]    = 1'b1;
            etype[b]   = T_PRESS;
          end
        end
        S_DOWN: begin
          if (!btn_in[b] && !prev_smp[b]) begin
            state_d[b] = S_IDLE;
            emit[b]    = 1'b1;
            etype[b]   = T_RELEASE;
          end else if (hold_q[b] == HW'(LONG_TICKS - 1)) begin
            state_d[b] = S_LONG;
            emit[b]    = 1'b1;
            etype[b]   = T_LONG;
`ifdef BTN_REPEAT_EN
            rep_d[b]   = '0;
`endif
          end else begin
            hold_d[b]  = hold_q[b] + HW'(1);
          end
        end
        S_LONG: begin
          if (!btn_in[b] && !prev_smp[b]) begin
            state_d[b] = S_IDLE;
            emit[b]    = 1'b1;
            etype[b]   = T_RELEASE;
          end else begin
`ifdef BTN_REPEAT_EN
            if (rep_q[b] == RW'(REPEAT_TICKS - 1)) begin
              rep_d[b] = '0;
              emit[b]  = 1'b1;
              etype[b] = T_REPEAT;
            end else begin
              rep_d[b] = rep_q[b] + RW'(1);
            end
`endif
          end
        end
        default: state_d[b] = S_IDLE;
      endcase
    end
  end

  // register this tick's events; btn_r goes first, btn_c waits one cycle when both fire
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_a_v    <= 1'b0;
      ev_a_code <= 3'b000;
      ev_b_v    <= 1'b0;
      ev_b_code <= 3'b000;
    end else if (tick) begin
      if (emit[0]) begin
        ev_a_v    <= 1'b1;
        ev_a_code <= {1'b0, etype[0]};
        ev_b_v    <= emit[1];
        ev_b_code <= {1'b1, etype[1]};
      end else begin
        ev_a_v    <= emit[1];
        ev_a_code <= {1'b1, etype[1]};
        ev_b_v    <= 1'b0;
        ev_b_code <= 3'b000;
      end
    end else begin
      ev_a_v    <= ev_b_v;
      ev_a_code <= ev_b_code;
      ev_b_v    <= 1'b0;
      ev_b_code <= 3'b000;
    end
  end

  assign full      = (evt_count == CW'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = ev_a_v & (~full | pop);
  assign evt_valid = (evt_count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : 3'b000;

  // show-ahead FIFO; a push into a full FIFO without a pop is dropped and flagged stickily
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= ev_a_code;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   evt_count <= evt_count + CW'(1);
        2'b01:   evt_count <= evt_count - CW'(1);
        default: evt_count <= evt_count;
      endcase
      if (ev_a_v && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - self-checking bench for btn_event_ctrl
module tb_btn_event_ctrl;
  localparam int L = 4;
  localparam int R = 2;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] btn_in;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // model state: FIFO contents, pending arrivals with their due edge, per-button press tracking
  int m_q[$];
  int arr_code[$];
  int arr_due[$];
  bit m_ovf;
  bit m_pr[2];
  int m_n[2];
  bit m_prev[2];
  int ecount;
  bit started;
  int log_q[$];

  btn_event_ctrl #(.LONG_TICKS(L), .REPEAT_TICKS(R), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // apply the rules for the upcoming posedge using the inputs that edge will sample
  task automatic model_step();
    bit popd;
    bit wasfull;
    int ev[2];
    int c;
    int due;
    if (rst) begin
      m_q.delete();
      arr_code.delete();
      arr_due.delete();
      m_ovf = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_pr[b] = 1'b0;
        m_n[b] = 0;
        m_prev[b] = 1'b0;
      end
    end else begin
      wasfull = (m_q.size() == D);
      popd = (m_q.size() > 0) && (evt_ready === 1'b1);
      if (popd) void'(m_q.pop_front());
      if (arr_due.size() > 0 && arr_due[0] == ecount) begin
        c = arr_code.pop_front();
        void'(arr_due.pop_front());
        if (!wasfull || popd) m_q.push_back(c);
        else m_ovf = 1'b1;
      end
      if (tick) begin
        for (int b = 0; b < 2; b++) begin
          ev[b] = -1;
          if (!m_pr[b] && btn_in[b] && m_prev[b]) begin
            ev[b] = 0;
            m_pr[b] = 1'b1;
            m_n[b] = 0;
          end else if (m_pr[b] && !btn_in[b] && !m_prev[b]) begin
            ev[b] = 1;
            m_pr[b] = 1'b0;
          end else if (m_pr[b]) begin
            m_n[b]++;
            if (m_n[b] == L) ev[b] = 2;
`ifdef BTN_REPEAT_EN
            else if (m_n[b] > L && ((m_n[b] - L) % R) == 0) ev[b] = 3;
`endif
          end
          m_prev[b] = btn_in[b];
        end
        due = ecount + 1;
        if (ev[0] >= 0) begin
          arr_code.push_back(ev[0]);
          arr_due.push_back(due);
          due++;
        end
        if (ev[1] >= 0) begin
          arr_code.push_back(4 + ev[1]);
          arr_due.push_back(due);
        end
      end
    end
    ecount++;
  endtask

  // every cycle: compare outputs against the model, log accepted events, then advance the model
  initial begin
    started = 1'b0;
    ecount = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("valid", evt_valid, (m_q.size() > 0) ? 1 : 0);
        chk("count", evt_count, m_q.size());
        chk("overflow", overflow, m_ovf);
        if (m_q.size() > 0) chk("code", evt_code, m_q[0]);
        if (evt_valid === 1'b1 && evt_ready === 1'b1 && rst === 1'b0) log_q.push_back(int'(evt_code));
      end
      model_step();
      started = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [1:0] b);
    btn_in = b;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(3);
  endtask

  task automatic chk_log(input string name, input int n, input int c0 = 0, input int c1 = 0,
                         input int c2 = 0, input int c3 = 0, input int c4 = 0);
    int e[5];
    e[0] = c0; e[1] = c1; e[2] = c2; e[3] = c3; e[4] = c4;
    chk({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) chk(name, log_q[i], e[i]);
    log_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    btn_in = 2'b00;
    evt_ready = 1'b0;
    step(3);
    rst = 1'b0;
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_overflow", overflow, 0);

    evt_ready = 1'b1;
    repeat (4) do_tick(2'b01);
    repeat (3) do_tick(2'b00);
    step(4);
    chk_log("btn_r_press_release", 2, 0, 1);
    chk("btn_r_overflow", overflow, 0);

    do_tick(2'b10);
    repeat (3) do_tick(2'b00);
    chk("glitch_count", evt_count, 0);
    chk_log("glitch", 0);

    repeat (10) do_tick(2'b10);
    repeat (3) do_tick(2'b00);
    step(4);
`ifdef BTN_REPEAT_EN
    chk_log("btn_c_long_repeat", 5, 4, 6, 7, 7, 5);
`else
    chk_log("btn_c_long", 3, 4, 6, 5);
`endif

    repeat (2) do_tick(2'b11);
    repeat (3) do_tick(2'b00);
    step(4);
    chk_log("both_buttons", 4, 0, 4, 1, 5);

    evt_ready = 1'b0;
    repeat (3) begin
      repeat (2) do_tick(2'b01);
      repeat (2) do_tick(2'b00);
    end
    step(4);
    chk("ovf_count", evt_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_code, 0);
    evt_ready = 1'b1;
    step(2);
    evt_ready = 1'b0;
    step(1);
    chk_log("ovf_order", 2, 0, 1);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_count_after_pop", evt_count, 2);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_count", evt_count, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_valid", evt_valid, 0);
    step(2);

    repeat (2) begin
      repeat (2) do_tick(2'b01);
      repeat (2) do_tick(2'b00);
    end
    chk("fill_count", evt_count, 4);
    do_tick(2'b01);
    btn_in = 2'b01;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(2);
    chk("full_pushpop_count", evt_count, 4);
    chk("full_pushpop_overflow", overflow, 0);
    evt_ready = 1'b1;
    step(6);
    chk_log("full_pushpop_order", 5, 0, 1, 0, 1, 0);
    chk("drain_count", evt_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
